// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch controller sitting between the PC, a
// synchronous instruction ROM and the decode/execute stage.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin fetching at the current PC (IDLE only)
//   halt_req          sticky request to stop at the next instruction boundary
//   redirect_valid    load redirect_pc (word aligned) as the next fetch PC
//   redirect_pc       redirect target, low two bits ignored
//   rom_data          ROM read data, valid ROM_LAT cycles after the address
//   instr_ready       downstream accepts instr_out
//   pc_out            ROM address / current PC
//   instr_out         captured instruction word
//   instr_pc          PC of instr_out
//   instr_valid       instr_out is offered downstream
//   busy              fetch in progress (ISSUE, WAIT, HOLD)
//   halted            controller stopped for good
//   fetch_count       saturating count of completed handshakes
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       ROM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [31:0]       rom_data,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  localparam int unsigned       CNT_W     = 2;
  localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(ROM_LAT - 1);
  localparam logic [31:0]       EBREAK    = 32'h0010_0073;
  localparam logic [15:0]       COUNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   wait_nxt;
  logic               halt_lat;
  logic               halt_pend;
  logic               capture;
  logic               handshake;
  logic [ADDR_W-1:0]  redir_pc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, next-PC and wait-counter logic
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_out;
    wait_nxt  = wait_cnt;
    capture   = 1'b0;
    handshake = instr_valid & instr_ready;
    halt_pend = halt_lat | halt_req;
    redir_pc  = redirect_pc & ~ADDR_W'(3);

    unique case (state)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_nxt = redir_pc;
        end
        if (halt_pend) begin
          state_nxt = S_HALT;
        end else if (start) begin
          state_nxt = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wait_nxt  = WAIT_INIT;
        state_nxt = S_WAIT;
        if (redirect_valid) begin
          pc_nxt    = redir_pc;
          state_nxt = S_ISSUE;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          // Drop the in-flight read and refetch from the target
          pc_nxt    = redir_pc;
          state_nxt = S_ISSUE;
        end else if (wait_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end else begin
          wait_nxt = wait_cnt - CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (handshake) begin
          // A redirect still loads the PC even when the halt path wins
          pc_nxt = redirect_valid ? redir_pc : pc_out + ADDR_W'(4);
          if (halt_pend || (instr_out == EBREAK)) begin
            state_nxt = S_HALT;
            if (!redirect_valid) begin
              pc_nxt = pc_out;
            end
          end else begin
            state_nxt = S_ISSUE;
          end
        end else if (redirect_valid) begin
          pc_nxt    = redir_pc;
          state_nxt = S_ISSUE;
        end
      end

      S_HALT: begin
        state_nxt = S_HALT;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered status outputs, all derived from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out      <= RESET_PC;
      wait_cnt    <= '0;
      halt_lat    <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc_out      <= pc_nxt;
      wait_cnt    <= wait_nxt;
      halt_lat    <= halt_pend;
      instr_valid <= (state_nxt == S_HOLD);
      busy        <= (state_nxt == S_ISSUE) || (state_nxt == S_WAIT) ||
                     (state_nxt == S_HOLD);
      halted      <= (state_nxt == S_HALT);
      if (capture) begin
        instr_out <= rom_data;
        instr_pc  <= pc_out;
      end
      if (handshake && (fetch_count != COUNT_MAX)) begin
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle fetch controller that sequences the PC, the synchronous instruction ROM and the instruction decoder. It replaces free-running PC increment with an explicit state machine, which adds start/halt control, branch redirect, and a valid/ready handshake toward the decode/execute stage. It owns the program counter and drives the ROM address. The decoder consumes `instr_out` directly.

## Interface
- `ADDR_W`, 8: PC / ROM address width.
- `ROM_LAT`, 1: ROM read latency in cycles, from address presented to data valid (range 1-4).
- `RESET_PC`, 0: PC value loaded on reset; must be word aligned.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle pulse that begins fetching at the current PC; honoured only in IDLE.
- `halt_req`  in  1  request to stop at the next instruction boundary; latched as sticky.
- `redirect_valid`  in  1  load a new PC (branch/jump).
- `redirect_pc`  in  ADDR_W  redirect target; bits [1:0] are forced to 0.
- `rom_data`  in  32  ROM read data.
- `instr_ready`  in  1  the downstream stage accepts `instr_out`.
- `pc_out`  out  ADDR_W  ROM address, equal to the current PC.
- `instr_out`  out  32  captured instruction.
- `instr_pc`  out  ADDR_W  PC of the instruction in `instr_out`.
- `instr_valid`  out  1  `instr_out` holds a valid instruction.
- `busy`  out  1  high in ISSUE, WAIT and HOLD.
- `halted`  out  1  high in HALT.
- `fetch_count`  out  16  number of completed handshakes; saturates at 0xFFFF.

## Operation
- States:
  - IDLE: waiting for `start`.
  - ISSUE: address presented to the ROM.
  - WAIT: latency countdown.
  - HOLD: instruction offered downstream.
  - HALT: stopped.
- IDLE:
  - `start` moves to ISSUE.
  - `redirect_valid` loads the PC and stays in IDLE.
  - A pending halt (a latched `halt_req`) moves to HALT, with priority over `start`.
- ISSUE: lasts one cycle. Loads the wait counter with ROM_LAT-1, then moves to WAIT.
- WAIT:
  - Counts down.
  - On the cycle the counter reads 0, captures `instr_out` <= `rom_data` and `instr_pc` <= PC, then moves to HOLD.
- HOLD:
  - `instr_valid` = 1. `instr_out` and `instr_pc` stay stable until the handshake.
  - Handshake = `instr_valid` & `instr_ready`.
  - On handshake, increment `fetch_count` (saturating), then choose the next state:
    - HALT if a halt is pending or `instr_out` == 32'h0010_0073 (EBREAK);
    - otherwise PC <= PC+4 (mod 2^ADDR_W; 0xFC wraps to 0x00) and go to ISSUE.
- Redirect in ISSUE, WAIT or HOLD:
  - PC <= `redirect_pc` & ~3 and the next state is ISSUE.
  - The in-flight read is discarded and `instr_valid` drops the next cycle.
  - Redirect overrides the PC+4 path.
- Redirect on the same cycle as a handshake:
  - The handshake counts: `fetch_count` increments and the instruction is consumed.
  - The next PC is the redirect target, not PC+4.
  - EBREAK or a pending halt still wins over redirect (the state goes to HALT, but the PC is still loaded).
- Redirect in HALT is ignored.
- `halt_req` during ISSUE or WAIT is latched and honoured after the HOLD handshake; the in-flight instruction is always delivered.
- HALT is terminal. Only `rst` leaves it; `start` is ignored.
- Reset values:
  - state = IDLE, PC = `pc_out` = RESET_PC;
  - `instr_out` = 0, `instr_pc` = 0, `instr_valid` = 0;
  - `busy` = 0, `halted` = 0, `fetch_count` = 0;
  - halt latch and wait counter cleared.
  - Reset in any state, including mid-WAIT, aborts immediately and drops `instr_valid` the next cycle.

## Timing
- All outputs are registered (Moore). No combinational path from inputs to outputs.
- With ROM_LAT=L and `start` sampled at edge 0:
  - ISSUE in cycle 1;
  - WAIT in cycles 2..L+1;
  - `instr_valid` high from cycle L+2.
- With `instr_ready` held at 1, one instruction completes every L+2 cycles: ISSUE, L×WAIT, HOLD.
- Back-pressure: each extra cycle with `instr_ready`=0 adds one cycle. No instruction is lost or duplicated.
- Redirect sampled at edge n puts `pc_out` = target in cycle n+1 (ISSUE). The first instruction from the target is valid L+1 cycles after that.
- `fetch_count` updates on the edge following the handshake.

## Test plan
- Reset then `start`, with ROM_LAT=1, `instr_ready`=1 and ROM[i] = i-th word:
  - `pc_out` sequence is 0,0,0,4,4,4,8…;
  - `instr_valid` is high every 3rd cycle;
  - after 4 instructions, `fetch_count` = 4.
- Back-pressure: hold `instr_ready`=0 for 5 cycles in HOLD.
  - `instr_out` and `instr_pc` stay stable throughout;
  - exactly one handshake occurs on release;
  - the next `pc_out` is +4.
- Redirect to 0x23 during WAIT:
  - the in-flight word is never valid;
  - `pc_out` = 0x20 next cycle;
  - the next `instr_pc` = 0x20.
  - Redirect on the handshake cycle: `fetch_count` increments and the next PC is the target.
- Halt behaviour:
  - Word 0x00100073 at PC 0x08: after its handshake, `halted`=1, `busy`=0, and `pc_out` stays 0x08.
  - `halt_req` during WAIT: the current instruction is delivered, then HALT.
  - `start` in HALT is ignored.
- Wrap and saturation:
  - PC 0xFC with a normal instruction wraps to 0x00.
  - With `fetch_count` forced to 0xFFFF via a long run, it stays 0xFFFF.
  - ROM_LAT=3 gives a 5-cycle period.
- Reset asserted mid-WAIT and mid-HOLD:
  - the next cycle shows all reset values;
  - `start` works normally afterwards.
